// File: rtl/hcordic_pkg.sv
// Shared helpers and constants for the scaling-free hyperbolic CORDIC pipeline:
// shift-width sizing, leading-one detection and the special-case shift/decrement.
package hcordic_pkg;

  // Shift issued when the residual's top magnitude bit is set; the residual
  // then drops by 2^(data_w-3) instead of losing its leading one.
  localparam int SPECIAL_SHIFT = 2;

  function automatic int special_dec_exp(input int data_w);
    return data_w - 3;
  endfunction

  function automatic int calc_sh_w(input int data_w);
    return $clog2(data_w) + 2;
  endfunction

  // Index of the highest set bit of v, or -1 when v is zero.
  function automatic int lead_one(input logic [63:0] v);
    int idx;
    idx = -1;
    for (int i = 0; i < 64; i++) begin
      if (v[i]) idx = i;
    end
    return idx;
  endfunction

endpackage

// File: rtl/hcordic_sf_stage.sv
// One combinational micro-rotation: rotate (x, y) by the incoming shift, then
// derive the next shift and reduced residual from the residual's leading one.
module hcordic_sf_stage
  import hcordic_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int SH_W   = calc_sh_w(DATA_W)
) (
  input  logic [DATA_W-1:0] x_i,
  input  logic [DATA_W-1:0] y_i,
  input  logic [DATA_W-1:0] t_i,
  input  logic [SH_W-1:0]   s_i,
  input  logic              conv_i,
  input  logic              ovf_i,
  output logic [DATA_W-1:0] x_o,
  output logic [DATA_W-1:0] y_o,
  output logic [DATA_W-1:0] t_o,
  output logic [SH_W-1:0]   s_o,
  output logic              conv_o,
  output logic              ovf_o
);

  localparam int SUM_W = DATA_W + 2;

  // Logical shift where any amount of DATA_W or more flushes to zero.
  function automatic logic [SUM_W-1:0] lsr(input logic [DATA_W-1:0] v, input int amt);
    logic [SUM_W-1:0] r;
    r = '0;
    if (amt < DATA_W) r = {2'b00, v >> amt};
    return r;
  endfunction

  int               s_int;
  int               ml;
  logic [SUM_W-1:0] sum_x;
  logic [SUM_W-1:0] sum_y;
  logic             rot_ovf;

  // Shift amounts are formed as int so 3s+2 cannot wrap in SH_W bits.
  always_comb begin
    s_int   = int'(s_i);
    sum_x   = {2'b00, x_i} + lsr(x_i, 2*s_int + 1) + lsr(y_i, 3*s_int + 2) + lsr(y_i, s_int);
    sum_y   = {2'b00, y_i} + lsr(y_i, 2*s_int + 1) + lsr(x_i, 3*s_int + 2) + lsr(x_i, s_int);
    x_o     = x_i;
    y_o     = y_i;
    rot_ovf = 1'b0;
    if (s_i != '0) begin
      x_o     = sum_x[DATA_W-1:0];
      y_o     = sum_y[DATA_W-1:0];
      rot_ovf = |{sum_x[SUM_W-1:DATA_W], sum_y[SUM_W-1:DATA_W]};
    end
    ovf_o = ovf_i | rot_ovf;
  end

  always_comb begin
    ml     = lead_one(64'(t_i[DATA_W-2:0]));
    s_o    = '0;
    t_o    = t_i;
    conv_o = conv_i;
    if (ml < 0) begin
      conv_o = 1'b1;
    end else if (ml == DATA_W - 2) begin
      s_o = SH_W'(SPECIAL_SHIFT);
      t_o = t_i - (DATA_W'(1) << special_dec_exp(DATA_W));
    end else begin
      s_o = SH_W'(DATA_W - 1 - ml);
      t_o = t_i & ~(DATA_W'(1) << ml) & ~(DATA_W'(1) << (DATA_W - 1));
    end
  end

endmodule

// File: rtl/hcordic_sf_pipe.sv
// Elastic STAGES-deep scaling-free hyperbolic CORDIC; the whole pipe advances
// together whenever the output slot is empty or being drained.
module hcordic_sf_pipe
  import hcordic_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int STAGES = 10,
  parameter int TAG_W  = 4,
  parameter int SH_W   = calc_sh_w(DATA_W)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_x,
  input  logic [DATA_W-1:0] in_y,
  input  logic [DATA_W-1:0] in_theta,
  input  logic [SH_W-1:0]   in_shift,
  input  logic [TAG_W-1:0]  in_tag,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_x,
  output logic [DATA_W-1:0] out_y,
  output logic [DATA_W-1:0] out_theta,
  output logic [SH_W-1:0]   out_shift,
  output logic [TAG_W-1:0]  out_tag,
  output logic              out_conv,
  output logic              out_ovf
);

  logic              adv;
  logic [STAGES-1:0] valid_q, valid_d;
  logic [DATA_W-1:0] x_q   [STAGES], x_d   [STAGES];
  logic [DATA_W-1:0] y_q   [STAGES], y_d   [STAGES];
  logic [DATA_W-1:0] t_q   [STAGES], t_d   [STAGES];
  logic [SH_W-1:0]   s_q   [STAGES], s_d   [STAGES];
  logic [TAG_W-1:0]  tag_q [STAGES], tag_d [STAGES];
  logic              conv_q [STAGES], conv_d [STAGES];
  logic              ovf_q  [STAGES], ovf_d  [STAGES];

  logic [DATA_W-1:0] src_x [STAGES], src_y [STAGES], src_t [STAGES];
  logic [SH_W-1:0]   src_s [STAGES];
  logic              src_conv [STAGES], src_ovf [STAGES];
  logic [DATA_W-1:0] st_x [STAGES], st_y [STAGES], st_t [STAGES];
  logic [SH_W-1:0]   st_s [STAGES];
  logic              st_conv [STAGES], st_ovf [STAGES];

  assign adv      = out_ready | ~valid_q[STAGES-1];
  assign in_ready = adv;

  // Stage 0 consumes the input port; every later stage consumes its predecessor's register.
  always_comb begin
    src_x[0]    = in_x;
    src_y[0]    = in_y;
    src_t[0]    = in_theta;
    src_s[0]    = in_shift;
    src_conv[0] = 1'b0;
    src_ovf[0]  = 1'b0;
    for (int i = 1; i < STAGES; i++) begin
      src_x[i]    = x_q[i-1];
      src_y[i]    = y_q[i-1];
      src_t[i]    = t_q[i-1];
      src_s[i]    = s_q[i-1];
      src_conv[i] = conv_q[i-1];
      src_ovf[i]  = ovf_q[i-1];
    end
  end

  for (genvar g = 0; g < STAGES; g++) begin : g_stage
    hcordic_sf_stage #(
      .DATA_W (DATA_W),
      .SH_W   (SH_W)
    ) u_stage (
      .x_i    (src_x[g]),
      .y_i    (src_y[g]),
      .t_i    (src_t[g]),
      .s_i    (src_s[g]),
      .conv_i (src_conv[g]),
      .ovf_i  (src_ovf[g]),
      .x_o    (st_x[g]),
      .y_o    (st_y[g]),
      .t_o    (st_t[g]),
      .s_o    (st_s[g]),
      .conv_o (st_conv[g]),
      .ovf_o  (st_ovf[g])
    );
  end

  always_comb begin
    // NOTE: every _d starts from its held value, so no branch can leave one unassigned and infer a latch.
    valid_d = valid_q;
    x_d     = x_q;
    y_d     = y_q;
    t_d     = t_q;
    s_d     = s_q;
    tag_d   = tag_q;
    conv_d  = conv_q;
    ovf_d   = ovf_q;
    if (adv) begin
      valid_d[0] = in_valid;
      tag_d[0]   = in_tag;
      for (int i = 0; i < STAGES; i++) begin
        x_d[i]    = st_x[i];
        y_d[i]    = st_y[i];
        t_d[i]    = st_t[i];
        s_d[i]    = st_s[i];
        conv_d[i] = st_conv[i];
        ovf_d[i]  = st_ovf[i];
      end
      for (int i = 1; i < STAGES; i++) begin
        valid_d[i] = valid_q[i-1];
        tag_d[i]   = tag_q[i-1];
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignment so every stage samples its
  // predecessor's pre-edge value; data registers are cleared too so outputs read zero after reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q <= '0;
      for (int i = 0; i < STAGES; i++) begin
        x_q[i]    <= '0;
        y_q[i]    <= '0;
        t_q[i]    <= '0;
        s_q[i]    <= '0;
        tag_q[i]  <= '0;
        conv_q[i] <= 1'b0;
        ovf_q[i]  <= 1'b0;
      end
    end else begin
      valid_q <= valid_d;
      x_q     <= x_d;
      y_q     <= y_d;
      t_q     <= t_d;
      s_q     <= s_d;
      tag_q   <= tag_d;
      conv_q  <= conv_d;
      ovf_q   <= ovf_d;
    end
  end

  assign out_valid = valid_q[STAGES-1];
  assign out_x     = x_q[STAGES-1];
  assign out_y     = y_q[STAGES-1];
  assign out_theta = t_q[STAGES-1];
  assign out_shift = s_q[STAGES-1];
  assign out_tag   = tag_q[STAGES-1];
  assign out_conv  = valid_q[STAGES-1] & conv_q[STAGES-1];
  assign out_ovf   = valid_q[STAGES-1] & ovf_q[STAGES-1];

endmodule

// File: tb/tb_hcordic_sf_pipe.sv
// Self-checking bench: directed vectors with literal expectations, plus a
// sample-level model and scoreboard compared against the main DUT every cycle.
module tb_hcordic_sf_pipe;

  localparam int DW = 16;
  localparam int NS = 10;
  localparam int TW = 4;
  localparam int SW = 6;

  typedef struct {
    logic [DW-1:0] x;
    logic [DW-1:0] y;
    logic [DW-1:0] t;
    logic [SW-1:0] s;
    logic [TW-1:0] tag;
    logic          conv;
    logic          ovf;
  } res_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Main DUT signals
  logic          in_valid = 1'b0, in_ready, out_valid, out_ready = 1'b1;
  logic [DW-1:0] in_x = '0, in_y = '0, in_theta = '0, out_x, out_y, out_theta;
  logic [SW-1:0] in_shift = '0, out_shift;
  logic [TW-1:0] in_tag = '0, out_tag;
  logic          out_conv, out_ovf;

  // Shared stimulus for the short-pipe instances
  logic          sp_valid = 1'b0, sp_oready = 1'b1;
  logic [DW-1:0] sp_x = '0, sp_y = '0, sp_t = '0;
  logic [SW-1:0] sp_s = '0;
  logic [TW-1:0] sp_tag = '0;
  logic          s1_ir, s1_ov, s1_conv, s1_ovf, s2_ir, s2_ov, s2_conv, s2_ovf;
  logic [DW-1:0] s1_x, s1_y, s1_t, s2_x, s2_y, s2_t;
  logic [SW-1:0] s1_s, s2_s;
  logic [TW-1:0] s1_tag, s2_tag;

  hcordic_sf_pipe #(.DATA_W(DW), .STAGES(NS), .TAG_W(TW)) u_dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_x(in_x), .in_y(in_y), .in_theta(in_theta), .in_shift(in_shift), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready), .out_x(out_x), .out_y(out_y),
    .out_theta(out_theta), .out_shift(out_shift), .out_tag(out_tag),
    .out_conv(out_conv), .out_ovf(out_ovf)
  );

  hcordic_sf_pipe #(.DATA_W(DW), .STAGES(1), .TAG_W(TW)) u_dut_s1 (
    .clk(clk), .reset(reset), .in_valid(sp_valid), .in_ready(s1_ir),
    .in_x(sp_x), .in_y(sp_y), .in_theta(sp_t), .in_shift(sp_s), .in_tag(sp_tag),
    .out_valid(s1_ov), .out_ready(sp_oready), .out_x(s1_x), .out_y(s1_y),
    .out_theta(s1_t), .out_shift(s1_s), .out_tag(s1_tag),
    .out_conv(s1_conv), .out_ovf(s1_ovf)
  );

  hcordic_sf_pipe #(.DATA_W(DW), .STAGES(2), .TAG_W(TW)) u_dut_s2 (
    .clk(clk), .reset(reset), .in_valid(sp_valid), .in_ready(s2_ir),
    .in_x(sp_x), .in_y(sp_y), .in_theta(sp_t), .in_shift(sp_s), .in_tag(sp_tag),
    .out_valid(s2_ov), .out_ready(sp_oready), .out_x(s2_x), .out_y(s2_y),
    .out_theta(s2_t), .out_shift(s2_s), .out_tag(s2_tag),
    .out_conv(s2_conv), .out_ovf(s2_ovf)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int shr(input int v, input int a);
    if (a >= DW) return 0;
    return v / (2 ** a);
  endfunction

  // Whole-sample model: walk the micro-rotations with plain integer arithmetic.
  function automatic res_t model(input logic [DW-1:0] x0, input logic [DW-1:0] y0,
                                 input logic [DW-1:0] t0, input logic [SW-1:0] s0,
                                 input int stages);
    res_t r;
    int x, y, t, s, nx, ny, low, ml;
    x = int'(x0); y = int'(y0); t = int'(t0); s = int'(s0);
    r.conv = 1'b0; r.ovf = 1'b0; r.tag = '0;
    for (int k = 0; k < stages; k++) begin
      if (s != 0) begin
        nx = x + shr(x, 2*s + 1) + shr(y, 3*s + 2) + shr(y, s);
        ny = y + shr(y, 2*s + 1) + shr(x, 3*s + 2) + shr(x, s);
        if (nx >= 65536 || ny >= 65536) r.ovf = 1'b1;
        x = nx % 65536;
        y = ny % 65536;
      end
      low = t % 32768;
      if (low == 0) begin
        r.conv = 1'b1;
        s = 0;
      end else begin
        ml = 0;
        while (2 ** (ml + 1) <= low) ml++;
        if (ml == 14) begin
          s = 2;
          t = t - 8192;
        end else begin
          s = 15 - ml;
          t = low - 2 ** ml;
        end
      end
    end
    r.x = 16'(x); r.y = 16'(y); r.t = 16'(t); r.s = 6'(s);
    return r;
  endfunction

  res_t       exp_q[$];
  logic [3:0] got_tags[$];

  // Scoreboard compare on the main DUT, every falling edge.
  always @(negedge clk) begin
    res_t e;
    if (reset) begin
      exp_q.delete();
    end else begin
      if (out_valid) begin
        if (exp_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL out_unexpected: tag 0x%0h emerged, expected no sample", out_tag);
          if (out_ready) got_tags.push_back(out_tag);
        end else begin
          e = exp_q[0];
          check("cmp_x",     32'(out_x),     32'(e.x));
          check("cmp_y",     32'(out_y),     32'(e.y));
          check("cmp_theta", 32'(out_theta), 32'(e.t));
          check("cmp_shift", 32'(out_shift), 32'(e.s));
          check("cmp_tag",   32'(out_tag),   32'(e.tag));
          check("cmp_conv",  32'(out_conv),  32'(e.conv));
          check("cmp_ovf",   32'(out_ovf),   32'(e.ovf));
          if (out_ready) begin
            void'(exp_q.pop_front());
            got_tags.push_back(out_tag);
          end
        end
      end else begin
        check("idle_conv", 32'(out_conv), 32'd0);
        check("idle_ovf",  32'(out_ovf),  32'd0);
      end
      if (in_valid && in_ready) begin
        e = model(in_x, in_y, in_theta, in_shift, NS);
        e.tag = in_tag;
        exp_q.push_back(e);
      end
    end
  end

  // Presents one sample and returns once it is accepted; in_valid is left high.
  task automatic send(input logic [DW-1:0] x, input logic [DW-1:0] y, input logic [DW-1:0] t,
                      input logic [SW-1:0] s, input logic [TW-1:0] tag, output int hs_cyc);
    bit ok;
    in_x = x; in_y = y; in_theta = t; in_shift = s; in_tag = tag; in_valid = 1'b1;
    ok = 1'b0;
    hs_cyc = 0;
    for (int k = 0; k < 64 && !ok; k++) begin
      @(negedge clk);
      if (in_ready) begin
        ok = 1'b1;
        hs_cyc = cyc;
      end
    end
    check("send_accepted", 32'(ok), 32'd1);
    @(posedge clk); #1;
  endtask

  task automatic single(input string nm, input logic [DW-1:0] x, input logic [DW-1:0] y,
                        input logic [DW-1:0] t, input logic [SW-1:0] s, input logic [TW-1:0] tag,
                        input logic [DW-1:0] ex, input logic [DW-1:0] ey, input logic [DW-1:0] et,
                        input logic [SW-1:0] es, input logic ec, input logic eo);
    int hs;
    bit seen;
    send(x, y, t, s, tag, hs);
    in_valid = 1'b0;
    seen = 1'b0;
    for (int k = 0; k < 40 && !seen; k++) begin
      @(negedge clk);
      if (out_valid) seen = 1'b1;
    end
    check({nm, "_seen"}, 32'(seen), 32'd1);
    if (seen) begin
      check({nm, "_latency"}, 32'(cyc - hs), 32'(NS));
      check({nm, "_x"},     32'(out_x),     32'(ex));
      check({nm, "_y"},     32'(out_y),     32'(ey));
      check({nm, "_theta"}, 32'(out_theta), 32'(et));
      check({nm, "_shift"}, 32'(out_shift), 32'(es));
      check({nm, "_tag"},   32'(out_tag),   32'(tag));
      check({nm, "_conv"},  32'(out_conv),  32'(ec));
      check({nm, "_ovf"},   32'(out_ovf),   32'(eo));
    end
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: run did not complete, %0d failed so far", n_fail);
    $fatal(1, "timeout");
  end

  initial begin
    res_t m;
    int hs;
    bit seen;
    logic [DW-1:0] th_tab [12];

    // Literal pins on the model itself
    m = model(16'h1000, 16'h0000, 16'h0000, 6'd4, NS);
    check("model_rot_x", 32'(m.x), 32'h1008);
    check("model_rot_y", 32'(m.y), 32'h0100);
    m = model(16'h0000, 16'h0000, 16'h3FFF, 6'd0, NS);
    check("model_res_t", 32'(m.t), 32'h000F);
    check("model_res_s", 32'(m.s), 32'd11);
    check("model_res_conv", 32'(m.conv), 32'd0);
    m = model(16'h1000, 16'h0000, 16'h4000, 6'd0, 1);
    check("model_sp1_t", 32'(m.t), 32'h2000);

    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_in_ready",  32'(in_ready),  32'd1);
    check("rst_out_x",     32'(out_x),     32'd0);
    check("rst_out_y",     32'(out_y),     32'd0);
    check("rst_out_theta", 32'(out_theta), 32'd0);
    check("rst_out_shift", 32'(out_shift), 32'd0);
    check("rst_out_tag",   32'(out_tag),   32'd0);
    check("rst_out_conv",  32'(out_conv),  32'd0);
    check("rst_out_ovf",   32'(out_ovf),   32'd0);
    @(posedge clk); #1;

    single("pass",   16'h1234, 16'h0042, 16'h0000, 6'd0, 4'h1, 16'h1234, 16'h0042, 16'h0000, 6'd0,  1'b1, 1'b0);
    single("rot",    16'h1000, 16'h0000, 16'h0000, 6'd4, 4'h2, 16'h1008, 16'h0100, 16'h0000, 6'd0,  1'b1, 1'b0);
    single("ovf_hi", 16'hFFFF, 16'hFFFF, 16'h0000, 6'd1, 4'h3, 16'hA7FC, 16'hA7FC, 16'h0000, 6'd0,  1'b1, 1'b1);
    single("ovf_lo", 16'h0100, 16'h0000, 16'h0000, 6'd1, 4'h4, 16'h0120, 16'h0088, 16'h0000, 6'd0,  1'b1, 1'b0);
    single("th4000", 16'h1000, 16'h0000, 16'h4000, 6'd0, 4'h5, 16'h120C, 16'h0860, 16'h0000, 6'd0,  1'b1, 1'b0);
    single("th3fff", 16'h0000, 16'h0000, 16'h3FFF, 6'd0, 4'h6, 16'h0000, 16'h0000, 16'h000F, 6'd11, 1'b0, 1'b0);

    // Special-case residual on one- and two-stage pipes
    sp_x = 16'h1000; sp_y = 16'h0000; sp_t = 16'h4000; sp_s = 6'd0; sp_tag = 4'h9; sp_valid = 1'b1;
    @(posedge clk); #1 sp_valid = 1'b0;
    @(negedge clk);
    m = model(16'h1000, 16'h0000, 16'h4000, 6'd0, 1);
    check("sp1_valid", 32'(s1_ov),   32'd1);
    check("sp1_shift", 32'(s1_s),    32'd2);
    check("sp1_theta", 32'(s1_t),    32'h2000);
    check("sp1_conv",  32'(s1_conv), 32'd0);
    check("sp1_x_model", 32'(s1_x),  32'(m.x));
    check("sp1_tag",   32'(s1_tag),  32'h9);
    @(negedge clk);
    m = model(16'h1000, 16'h0000, 16'h4000, 6'd0, 2);
    check("sp1_bubble", 32'(s1_ov),  32'd0);
    check("sp2_valid", 32'(s2_ov),   32'd1);
    check("sp2_shift", 32'(s2_s),    32'd2);
    check("sp2_theta", 32'(s2_t),    32'h0000);
    check("sp2_conv",  32'(s2_conv), 32'd0);
    check("sp2_x",     32'(s2_x),    32'h1080);
    check("sp2_y",     32'(s2_y),    32'h0410);
    check("sp2_y_model", 32'(s2_y),  32'(m.y));
    @(posedge clk); #1;

    // Backpressure: 12 tagged samples, 15-cycle output stall once the pipe fills
    th_tab = '{16'h0000, 16'h4000, 16'h3FFF, 16'hC000, 16'h0001, 16'h1234,
               16'h0000, 16'h0F0F, 16'h2000, 16'h7FFF, 16'h0100, 16'h8001};
    got_tags.delete();
    fork
      begin
        int h;
        for (int i = 0; i < 12; i++)
          send(16'(16'h0100 + i * 16'h0123), 16'(i * 16'h0045), th_tab[i], 6'(i % 5), 4'(i), h);
        in_valid = 1'b0;
      end
      begin
        bit full;
        full = 1'b0;
        for (int k = 0; k < 40 && !full; k++) begin
          @(negedge clk);
          if (out_valid) full = 1'b1;
        end
        check("bp_filled", 32'(full), 32'd1);
        @(posedge clk); #1 out_ready = 1'b0;
        for (int k = 0; k < 15; k++) begin
          @(negedge clk);
          check("bp_stall_in_ready",  32'(in_ready),  32'd0);
          check("bp_stall_out_valid", 32'(out_valid), 32'd1);
          check("bp_stall_out_tag",   32'(out_tag),   32'd1);
        end
        @(posedge clk); #1 out_ready = 1'b1;
      end
    join
    seen = 1'b0;
    for (int k = 0; k < 60 && !seen; k++) begin
      @(negedge clk);
      if (got_tags.size() >= 12) seen = 1'b1;
    end
    repeat (3) @(negedge clk);
    check("bp_count", 32'(got_tags.size()), 32'd12);
    for (int i = 0; i < 12 && i < got_tags.size(); i++)
      check("bp_tag_order", 32'(got_tags[i]), 32'(i));
    @(posedge clk); #1;

    // Reset with five samples in flight
    got_tags.delete();
    for (int i = 0; i < 5; i++) send(16'h0200, 16'h0010, 16'h0000, 6'd2, 4'(10 + i), hs);
    in_valid = 1'b0;
    reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
    @(negedge clk);
    check("rst_mid_out_valid", 32'(out_valid), 32'd0);
    check("rst_mid_in_ready",  32'(in_ready),  32'd1);
    @(posedge clk); #1;
    single("fresh", 16'h0100, 16'h0000, 16'h0000, 6'd1, 4'hF, 16'h0120, 16'h0088, 16'h0000, 6'd0, 1'b1, 1'b0);
    repeat (12) @(negedge clk);
    check("rst_mid_count", 32'(got_tags.size()), 32'd1);
    if (got_tags.size() > 0) check("rst_mid_tag", 32'(got_tags[0]), 32'hF);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
